pbpix_fifo: RTL and testbench
=============================

Name: pbpix_fifo

Overview:
- Parametrised FIFO for the pbpix handshake (rdy/ack plus per-beat zero flag), carrying a DW-bit payload beside the flag.
- Decouples a pixel producer from a consumer in the accelerator datapath; the zero flag travels with each entry.
- Generalises the fixed pbpix port bundle: configurable width and depth, occupancy output and synchronous flush.

Parameters:
- DW, 8, payload width in bits (>=1)
- DEPTH, 4, number of entries; power of two, >=2
- AW, $clog2(DEPTH), derived pointer width; not overridden

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  reset; asynchronous, active-low
- i_flush  input  1  synchronous clear of all entries
- src_rdy  input  1  producer has a valid beat
- src_ack  output  1  FIFO accepts the beat
- src_zero  input  1  beat is a zero pixel
- src_data  input  DW  beat payload
- dst_rdy  output  1  FIFO head valid
- dst_ack  input  1  consumer takes the head
- dst_zero  output  1  zero flag of the head
- dst_data  output  DW  payload of the head
- o_cnt  output  AW+1  occupancy, 0..DEPTH

Behaviour:
- Clock and reset: i_clk; reset i_rstn, asynchronous, active-low.
- Transfer rule: a beat moves only when rdy && ack are high in the same cycle, on either side.
- The producer holds src_rdy, src_zero and src_data stable until acked. The FIFO holds dst_rdy, dst_zero and dst_data stable until dst_ack.
- Storage: DEPTH entries of {zero, data}. Read and write pointers are AW+1 bits including a wrap bit.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
  - Pointers wrap naturally modulo 2*DEPTH.
- Handshake outputs:
  - src_ack = !full && !i_flush. Derived from registered state only; no combinational path from dst_ack.
  - dst_rdy = !empty. dst_zero and dst_data come from the head entry, with a registered-index mux.
- Latency: a beat accepted in cycle t is visible at dst in cycle t+1 at the earliest. There is no same-cycle bypass.
- Push and pop in the same cycle (neither full nor empty): both occur and o_cnt is unchanged.
- Full: src_ack=0 even when dst_ack=1 in that cycle. Space reappears the cycle after the pop.
- Empty: dst_rdy=0 and dst_ack is ignored. dst_zero and dst_data are don't-care; the bench must not check them.
- o_cnt: registered. +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- i_flush=1: on the next edge both pointers go to 0 and o_cnt to 0.
  - During the flush cycle a push is refused (src_ack=0).
  - A pop handshake in the same cycle is discarded; the consumer sees it as completed, but the entry is dropped anyway.
- Reset (any time, including mid-transfer): pointers=0, o_cnt=0, dst_rdy=0, src_ack=1 after release, dst_zero=0, dst_data=0.
  - Storage contents are not reset.
  - A beat in flight at reset assertion is lost.

Optional Feature:
- Macro PBPIX_FIFO_ZGATE_EN.
- Defined:
  - The data storage write enable is gated off when src_zero=1 (power saving); only the zero flag is written.
  - dst_data is forced to 0 whenever dst_zero=1.
- Undefined:
  - src_data is always stored.
  - dst_data returns the stored payload regardless of dst_zero.
- Handshake timing, o_cnt and the flag path are identical in both builds.

Test Plan:
1. Reset then idle, DW=8, DEPTH=4: after release src_ack=1, dst_rdy=0, o_cnt=0, dst_data=0, dst_zero=0.
2. Fill with dst_ack=0, push 0x11,0x22,0x33,0x44: o_cnt 1,2,3,4; src_ack=0 at o_cnt=4; a fifth beat 0x55 held with src_rdy=1 is not accepted. Then dst_ack=1: pops 0x11..0x44 in order, and 0x55 is accepted the cycle after the first pop.
3. Continuous streaming, src_rdy=dst_ack=1 for 20 beats 0x00..0x13: o_cnt settles at 1, output order equals input order. Pointer wrap is crossed at least 4 times with no loss or duplication.
4. Zero flag, push {zero=1, data=0xAB} then {zero=0, data=0xCD}: dst_zero sequence 1,0. dst_data 0x00,0xCD with PBPIX_FIFO_ZGATE_EN; 0xAB,0xCD without.
5. Flush, 3 entries held, assert i_flush with src_rdy=1 and dst_ack=1: src_ack=0 that cycle; next cycle o_cnt=0 and dst_rdy=0. A subsequent push of 0x77 emerges first.
6. Reset mid-operation, 2 entries held, pulse i_rstn low asynchronously between edges: dst_rdy drops to 0 immediately and o_cnt=0; after release, a push of 0x5A emerges alone.

Source files
------------

// File: rtl/pbpix_fifo.sv
// pbpix_fifo: pbpix rdy/ack FIFO carrying a DW-bit payload plus a per-beat
// zero flag. It has an occupancy count and a synchronous flush.
// Optional build macro PBPIX_FIFO_ZGATE_EN:
//   - zero beats skip the payload write;
//   - dst_data reads as 0 whenever dst_zero is set.
module pbpix_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_flush,
   input  logic          src_rdy,
   output logic          src_ack,
   input  logic          src_zero,
   input  logic [DW-1:0] src_data,
   output logic          dst_rdy,
   input  logic          dst_ack,
   output logic          dst_zero,
   output logic [DW-1:0] dst_data,
   output logic [AW:0]   o_cnt
);

   // Storage is never reset.
   // The outputs are masked while the FIFO is empty, so stale contents never show.
   logic [DW-1:0] data_mem [DEPTH];
   logic          zero_mem [DEPTH];

   logic [AW:0]   wptr, rptr, cnt;
   logic [AW-1:0] widx, ridx;
   logic          full, empty, push, pop;

   assign widx  = wptr[AW-1:0];
   assign ridx  = rptr[AW-1:0];
   assign full  = (wptr[AW] != rptr[AW]) && (widx == ridx);
   assign empty = (wptr == rptr);

   // The ack depends only on registered state and flush.
   // The consumer side (dst_ack) has no combinational path to it.
   assign src_ack = !full && !i_flush;
   assign dst_rdy = !empty;
   assign push    = src_rdy && src_ack;
   assign pop     = dst_rdy && dst_ack;
   assign o_cnt   = cnt;

   // Pointer and occupancy update.
   // Flush overrides everything, including a same-cycle pop.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (i_flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Zero-flag write. The flag is always stored with the beat.
   always_ff @(posedge i_clk) begin
      if (push) zero_mem[widx] <= src_zero;
   end

   // Payload write. With gating, a zero beat leaves the payload entry untouched.
   always_ff @(posedge i_clk) begin
`ifdef PBPIX_FIFO_ZGATE_EN
      if (push && !src_zero) data_mem[widx] <= src_data;
`else
      if (push) data_mem[widx] <= src_data;
`endif
   end

   // Head read, indexed by the registered read pointer.
   // The outputs are forced to 0 when the FIFO is empty so they read 0 after reset.
   always_comb begin
      dst_zero = 1'b0;
      dst_data = '0;
      if (!empty) begin
         dst_zero = zero_mem[ridx];
`ifdef PBPIX_FIFO_ZGATE_EN
         dst_data = zero_mem[ridx] ? '0 : data_mem[ridx];
`else
         dst_data = data_mem[ridx];
`endif
      end
   end

endmodule

// File: tb/tb_pbpix_fifo.sv
// tb_pbpix_fifo: self-checking bench for pbpix_fifo (DW=8, DEPTH=4).
// A scoreboard queue records the beats accepted at the source.
// Each head popped at the destination is compared with the oldest entry.
// Honours PBPIX_FIFO_ZGATE_EN for the expected payload of zero beats.
module tb_pbpix_fifo;

   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic          flush;
   logic          s_rdy, s_zero;
   logic [DW-1:0] s_data;
   logic          s_ack;
   logic          d_rdy, d_ack, d_zero;
   logic [DW-1:0] d_data;
   logic [AW:0]   cnt;

   pbpix_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
      .src_rdy(s_rdy), .src_ack(s_ack), .src_zero(s_zero), .src_data(s_data),
      .dst_rdy(d_rdy), .dst_ack(d_ack), .dst_zero(d_zero), .dst_data(d_data),
      .o_cnt(cnt)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nfail = 0;
   int npop = 0;
   logic [DW:0] sb [$];
   logic          smp_ack, smp_rdy;
   logic [AW:0]   smp_cnt;

   typedef struct {
      logic r; logic z; logic [7:0] d; logic a; logic f;
      logic e_ack; logic e_rdy; logic [2:0] e_cnt;
   } vec_t;

   vec_t vt [11];

   function automatic vec_t mk(input logic r, input logic [7:0] d, input logic a,
                               input logic e_ack, input logic e_rdy,
                               input logic [2:0] e_cnt);
      vec_t v;
      v.r = r; v.z = 1'b0; v.d = d; v.a = a; v.f = 1'b0;
      v.e_ack = e_ack; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive, sample at negedge (scoreboard), then pass the edge.
   task automatic cyc(input logic r, input logic z, input logic [7:0] d,
                      input logic a, input logic f);
      logic [DW:0] e;
      logic [DW-1:0] ed;
      s_rdy = r; s_zero = z; s_data = d; d_ack = a; flush = f;
      @(negedge clk);
      smp_ack = s_ack; smp_rdy = d_rdy; smp_cnt = cnt;
      if (d_rdy && d_ack) begin
         npop++;
         if (sb.size() == 0) begin
            ncmp++; nfail++;
            $display("FAIL pop_unexpected: got data 0x%0h, want none", d_data);
         end else begin
            e = sb.pop_front();
`ifdef PBPIX_FIFO_ZGATE_EN
            ed = e[DW] ? '0 : e[DW-1:0];
`else
            ed = e[DW-1:0];
`endif
            chk("pop_zero", {31'd0, d_zero}, {31'd0, e[DW]});
            chk("pop_data", {24'd0, d_data}, {24'd0, ed});
         end
      end
      if (s_rdy && s_ack) sb.push_back({s_zero, s_data});
      if (f) sb.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      // Fill to full with the consumer stalled, hold a fifth beat, then drain.
      vt[0]  = mk(1, 8'h11, 0, 1, 0, 0);
      vt[1]  = mk(1, 8'h22, 0, 1, 1, 1);
      vt[2]  = mk(1, 8'h33, 0, 1, 1, 2);
      vt[3]  = mk(1, 8'h44, 0, 1, 1, 3);
      vt[4]  = mk(1, 8'h55, 0, 0, 1, 4);
      vt[5]  = mk(1, 8'h55, 1, 0, 1, 4);
      vt[6]  = mk(1, 8'h55, 1, 1, 1, 3);
      vt[7]  = mk(0, 8'h00, 1, 1, 1, 3);
      vt[8]  = mk(0, 8'h00, 1, 1, 1, 2);
      vt[9]  = mk(0, 8'h00, 1, 1, 1, 1);
      vt[10] = mk(0, 8'h00, 1, 1, 0, 0);

      rstn = 1'b0; flush = 1'b0; s_rdy = 1'b0; s_zero = 1'b0; s_data = '0; d_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("rst_src_ack", {31'd0, s_ack}, 32'd1);
      chk("rst_dst_rdy", {31'd0, d_rdy}, 32'd0);
      chk("rst_cnt", {29'd0, cnt}, 32'd0);
      chk("rst_data", {24'd0, d_data}, 32'd0);
      chk("rst_zero", {31'd0, d_zero}, 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         cyc(vt[i].r, vt[i].z, vt[i].d, vt[i].a, vt[i].f);
         chk($sformatf("vec%0d_src_ack", i), {31'd0, smp_ack}, {31'd0, vt[i].e_ack});
         chk($sformatf("vec%0d_dst_rdy", i), {31'd0, smp_rdy}, {31'd0, vt[i].e_rdy});
         chk($sformatf("vec%0d_cnt", i), {29'd0, smp_cnt}, {29'd0, vt[i].e_cnt});
      end
      chk("fill_sb_empty", sb.size(), 0);

      // Continuous streaming: the count settles at 1 and every beat emerges once.
      p0 = npop;
      for (int i = 0; i < 20; i++) begin
         cyc(1, 0, 8'(i), 1, 0);
         chk("stream_cnt", {29'd0, smp_cnt}, (i == 0) ? 32'd0 : 32'd1);
      end
      cyc(0, 0, 8'h00, 1, 0);
      chk("stream_pops", npop - p0, 20);
      chk("stream_sb_empty", sb.size(), 0);
      chk("stream_cnt_end", {29'd0, cnt}, 32'd0);

      // The zero flag travels with its beat.
      cyc(1, 1, 8'hAB, 0, 0);
      cyc(1, 0, 8'hCD, 0, 0);
      cyc(0, 0, 8'h00, 1, 0);
      cyc(0, 0, 8'h00, 1, 0);
      chk("zero_sb_empty", sb.size(), 0);

      // Flush while holding 3 entries, with both sides active.
      cyc(1, 0, 8'hA1, 0, 0);
      cyc(1, 0, 8'hA2, 0, 0);
      cyc(1, 0, 8'hA3, 0, 0);
      cyc(1, 0, 8'h99, 1, 1);
      chk("flush_src_ack", {31'd0, smp_ack}, 32'd0);
      cyc(0, 0, 8'h00, 0, 0);
      chk("flush_cnt", {29'd0, smp_cnt}, 32'd0);
      chk("flush_dst_rdy", {31'd0, smp_rdy}, 32'd0);
      cyc(1, 0, 8'h77, 0, 0);
      cyc(0, 0, 8'h00, 1, 0);
      cyc(0, 0, 8'h00, 1, 0);
      chk("flush_after_rdy", {31'd0, smp_rdy}, 32'd0);
      chk("flush_sb_empty", sb.size(), 0);

      // An asynchronous reset pulse between edges while holding 2 entries.
      cyc(1, 0, 8'hB1, 0, 0);
      cyc(1, 0, 8'hB2, 0, 0);
      s_rdy = 1'b0;
      #1 rstn = 1'b0;
      #1;
      chk("arst_dst_rdy", {31'd0, d_rdy}, 32'd0);
      chk("arst_cnt", {29'd0, cnt}, 32'd0);
      sb.delete();
      #1 rstn = 1'b1;
      cyc(1, 0, 8'h5A, 0, 0);
      chk("arst_src_ack", {31'd0, smp_ack}, 32'd1);
      cyc(0, 0, 8'h00, 1, 0);
      cyc(0, 0, 8'h00, 1, 0);
      chk("arst_alone", {31'd0, smp_rdy}, 32'd0);
      chk("arst_sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
